// File: rtl/time_edit_ctrl.sv
// Edit sequencer for the seconds/minutes/hours BCD registers of the RTC interface.
// Forwards RTC updates in run mode, drives per-field modify/step controls in edit mode.
module time_edit_ctrl #(
   parameter int CNT_W        = 32,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int TIMEOUT      = 500000000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_btn_edit,
   input  logic       i_btn_next,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_rtc_valid,
   input  logic       i_wr_ack,
   output logic [2:0] o_mod_sel,
   output logic       o_up_out,
   output logic       o_down_out,
   output logic       o_actualizar,
   output logic       o_wr_req,
   output logic       o_edit_active
);

   typedef enum logic [2:0] {
      S_RUN    = 3'd0,
      S_SEC    = 3'd1,
      S_MIN    = 3'd2,
      S_HOR    = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      D_NONE = 2'd0,
      D_UP   = 2'd1,
      D_DOWN = 2'd2
   } dir_t;

   localparam logic [CNT_W-1:0] L_DELAY = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] L_RATE  = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] L_TO_M1 = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] L_MAX   = {CNT_W{1'b1}};

   state_t           r_state;
   dir_t             r_prev_dir;
   logic [CNT_W-1:0] r_rpt_cnt;
   logic [CNT_W-1:0] r_idle_cnt;
   logic             r_rpt_first;
   logic             r_disarm;

   dir_t             w_dir;
   state_t           w_state_nxt;
   logic             w_in_edit;
   logic             w_timeout;
   logic             w_leave;
   logic             w_fire;
   logic [CNT_W-1:0] w_rpt_target;
   logic [CNT_W-1:0] w_rpt_cnt_nxt;
   logic             w_rpt_first_nxt;
   logic [CNT_W-1:0] w_idle_cnt_nxt;
   logic             w_disarm_nxt;

   // Input decode: active direction (UP has priority) and edit-exit conditions
   always_comb begin
      if (i_btn_up) begin
         w_dir = D_UP;
      end else if (i_btn_down) begin
         w_dir = D_DOWN;
      end else begin
         w_dir = D_NONE;
      end
      w_in_edit = (r_state == S_SEC) || (r_state == S_MIN) || (r_state == S_HOR);
      w_timeout = w_in_edit && !i_btn_edit && !i_btn_next && !i_btn_up && !i_btn_down
                  && (r_idle_cnt >= L_TO_M1);
      w_leave   = w_in_edit && (i_btn_edit || i_btn_next || w_timeout);
   end

   // Next state; EDIT outranks NEXT and timeout in the edit states
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (i_btn_edit) w_state_nxt = S_SEC;
            else            w_state_nxt = S_RUN;
         end
         S_SEC, S_MIN, S_HOR: begin
            if (i_btn_edit) begin
               w_state_nxt = S_COMMIT;
            end else if (i_btn_next) begin
               case (r_state)
                  S_SEC:   w_state_nxt = S_MIN;
                  S_MIN:   w_state_nxt = S_HOR;
                  default: w_state_nxt = S_SEC;
               endcase
            end else if (w_timeout) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_COMMIT: begin
            if (i_wr_ack) w_state_nxt = S_RUN;
            else          w_state_nxt = S_COMMIT;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Auto-repeat, disarm and idle-timeout bookkeeping
   always_comb begin
      w_rpt_target = r_rpt_first ? L_DELAY : L_RATE;
      w_fire = w_in_edit && !w_leave && !r_disarm && (w_dir != D_NONE)
               && ((w_dir != r_prev_dir) || (r_rpt_cnt >= w_rpt_target));

      if (!w_in_edit || w_leave || r_disarm || (w_dir == D_NONE)) begin
         w_rpt_cnt_nxt   = L_ZERO;
         w_rpt_first_nxt = 1'b0;
      end else if (w_fire) begin
         w_rpt_cnt_nxt   = L_ONE;
         w_rpt_first_nxt = (w_dir != r_prev_dir);
      end else begin
         w_rpt_cnt_nxt   = (r_rpt_cnt == L_MAX) ? r_rpt_cnt : r_rpt_cnt + L_ONE;
         w_rpt_first_nxt = r_rpt_first;
      end

      if (!w_in_edit || i_btn_edit || i_btn_next || i_btn_up || i_btn_down || w_timeout) begin
         w_idle_cnt_nxt = L_ZERO;
      end else begin
         w_idle_cnt_nxt = (r_idle_cnt == L_MAX) ? r_idle_cnt : r_idle_cnt + L_ONE;
      end

      // A hold that spans a field change or edit entry must be released before it steps again
      if (((r_state == S_RUN) && i_btn_edit) || (w_in_edit && i_btn_next && !i_btn_edit)) begin
         w_disarm_nxt = i_btn_up || i_btn_down;
      end else if (!i_btn_up && !i_btn_down) begin
         w_disarm_nxt = 1'b0;
      end else begin
         w_disarm_nxt = r_disarm;
      end
   end

   // State register and registered outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= S_RUN;
         r_prev_dir    <= D_NONE;
         r_rpt_cnt     <= L_ZERO;
         r_idle_cnt    <= L_ZERO;
         r_rpt_first   <= 1'b0;
         r_disarm      <= 1'b0;
         o_mod_sel     <= 3'b000;
         o_up_out      <= 1'b0;
         o_down_out    <= 1'b0;
         o_actualizar  <= 1'b0;
         o_wr_req      <= 1'b0;
         o_edit_active <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_prev_dir    <= w_dir;
         r_rpt_cnt     <= w_rpt_cnt_nxt;
         r_idle_cnt    <= w_idle_cnt_nxt;
         r_rpt_first   <= w_rpt_first_nxt;
         r_disarm      <= w_disarm_nxt;
         case (w_state_nxt)
            S_SEC:   o_mod_sel <= 3'b001;
            S_MIN:   o_mod_sel <= 3'b010;
            S_HOR:   o_mod_sel <= 3'b100;
            default: o_mod_sel <= 3'b000;
         endcase
         o_up_out      <= w_fire && (w_dir == D_UP);
         o_down_out    <= w_fire && (w_dir == D_DOWN);
         o_actualizar  <= (r_state == S_RUN) && i_rtc_valid && !i_btn_edit;
         o_wr_req      <= (w_state_nxt == S_COMMIT);
         o_edit_active <= (w_state_nxt != S_RUN);
      end
   end

endmodule

// File: doc/time_edit_ctrl.md
Name: time_edit_ctrl

Overview:
Sequencer for the three BCD time-field registers (seconds, minutes, hours) of the RTC interface.
- In normal run, it forwards RTC read-valid strobes as the register update strobe.
- In edit mode, it selects one field at a time and drives that field's modify, increment and decrement controls, with press-and-hold auto-repeat.
- On exit, it requests a write-back of the edited values to the RTC.

Parameters:
CNT_W, 32, width of the repeat and timeout counters
REPEAT_DELAY, 25000000, cycles from the first UP/DOWN pulse to the first auto-repeat pulse
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses
TIMEOUT, 500000000, consecutive idle cycles in an edit state before edit is aborted

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  synchronous reset, active-low
BTN_EDIT  in  1  one-cycle pulse, debounced upstream: enter or commit edit
BTN_NEXT  in  1  one-cycle pulse: advance to the next field
BTN_UP  in  1  level, debounced: increment held
BTN_DOWN  in  1  level, debounced: decrement held
RTC_VALID  in  1  one-cycle pulse: fresh BCD time on the register data inputs
WR_ACK  in  1  one-cycle pulse: RTC writer has accepted the write-back
MOD_SEL  out  3  one-hot modify enable: [0] seconds, [1] minutes, [2] hours
UP_OUT  out  1  one-cycle increment pulse to the selected field
DOWN_OUT  out  1  one-cycle decrement pulse to the selected field
ACTUALIZAR  out  1  one-cycle load strobe to all field registers
WR_REQ  out  1  write-back request, held until acknowledged
EDIT_ACTIVE  out  1  high in any edit or commit state

Behaviour:
- Clock and reset: one clock CLK; reset is synchronous and active-low (RST_N). RST_N=0 at a rising edge gives state RUN, all outputs 0, counters 0 and repeat flags cleared. This applies mid-edit and mid-commit, and no write is issued.
- Latency: all outputs are registered. An input event at edge n produces its output at edge n+1.
- States: RUN, E_SEC, E_MIN, E_HOR, COMMIT.
- MOD_SEL by state: RUN 000, E_SEC 001, E_MIN 010, E_HOR 100, COMMIT 000. EDIT_ACTIVE=1 in all states except RUN.
- RUN:
  - ACTUALIZAR = RTC_VALID delayed by one cycle.
  - BTN_EDIT moves to E_SEC. BTN_NEXT, BTN_UP and BTN_DOWN are ignored.
- E_* (edit states):
  - ACTUALIZAR is forced to 0. An RTC_VALID arriving in E_* or COMMIT is dropped, not deferred.
  - BTN_NEXT moves E_SEC->E_MIN->E_HOR->E_SEC (wrap).
  - BTN_EDIT moves to COMMIT. If BTN_EDIT and BTN_NEXT arrive in the same cycle, BTN_EDIT wins.
- COMMIT:
  - WR_REQ=1 from the entry cycle until the cycle after WR_ACK is seen; the state then returns to RUN.
  - All buttons are ignored. UP_OUT and DOWN_OUT are 0.
  - A WR_ACK seen in any other state is ignored.
- Auto-repeat (edit states only):
  - Active direction is UP if BTN_UP=1, else DOWN if BTN_DOWN=1. When both are held, only UP_OUT pulses.
  - A rising edge of the active direction gives one pulse, then a pulse every REPEAT_DELAY cycles for the first repeat and every REPEAT_RATE cycles after that, while the direction is held.
  - Releasing, or changing direction, restarts the sequence.
- Field change mid-hold: on any BTN_NEXT, the repeat logic disarms. No further pulses are produced until BTN_UP and BTN_DOWN are both 0 for at least one cycle.
- UP_OUT and DOWN_OUT are never asserted in the cycle where the state leaves an E_* state.
- Timeout:
  - The idle counter clears on edit entry, on BTN_NEXT, and on any cycle with BTN_UP or BTN_DOWN high.
  - After TIMEOUT consecutive idle cycles in E_*, the next state is RUN with no write (abort). The next RTC_VALID then reloads the registers.
  - If BTN_EDIT arrives in the same cycle as the timeout, COMMIT wins.
- Counters saturate and never wrap. Auto-repeat counts only while a direction is held.

Test Plan:
(Overrides for all tests: REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT=32.)
1. Reset, then RTC_VALID pulses at cycles 5 and 20 -> ACTUALIZAR high at cycles 6 and 21 only; MOD_SEL=000, EDIT_ACTIVE=0.
2. BTN_EDIT at cycle 10, then BTN_NEXT at 12, 14 and 16 -> MOD_SEL 001@11, 010@13, 100@15, 001@17; ACTUALIZAR stays 0 despite an RTC_VALID at 13.
3. In E_MIN, BTN_UP rises at cycle 100 and is held to 130 -> UP_OUT pulses at 101, 109, 113, 117, 121, 125, 129; DOWN_OUT=0. Repeat with both buttons held -> identical UP_OUT sequence, DOWN_OUT=0.
4. BTN_UP held while BTN_NEXT pulses -> no UP_OUT until BTN_UP has been low for at least one cycle; re-press gives an immediate pulse on the new field.
5. BTN_EDIT in E_HOR at cycle 50, WR_ACK at 60 -> WR_REQ=1 for cycles 51..60, state RUN and EDIT_ACTIVE=0 at 61; button pulses during 51..60 have no effect.
6. Enter edit and stay idle -> RUN after 32 idle cycles, WR_REQ never asserted. Separately, drive RST_N=0 in COMMIT -> WR_REQ=0 and MOD_SEL=000 on the next edge.
